// File: rtl/cdu_pulse_scheduler_if.sv
// Pulse request handshake between the scheduler (master) and the computer interface (slave).
// The request holds axis and sign stable until the slave acknowledges it.
interface cdu_pulse_scheduler_if;
  logic       out_req;
  logic [1:0] out_axis;
  logic       out_sign;
  logic       out_ack;

  modport master (output out_req, output out_axis, output out_sign, input out_ack);
  modport slave  (input out_req, input out_axis, input out_sign, output out_ack);
endinterface

// File: rtl/cdu_pulse_scheduler.sv
// Accumulates signed per-axis angle pulses; grants one round-robin pulse per slot, OUT_REQ 1 cycle after SLOT.
// Holds the request until acknowledged; TMO unacknowledged slots time out and restore the pulse.
module cdu_pulse_scheduler #(
  parameter int CNT_W = 4,
  parameter int TMO   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  slot,
  input  logic                  a_pls,
  input  logic                  b_pls,
  input  logic                  c_pls,
  input  logic                  a_dir,
  input  logic                  b_dir,
  input  logic                  c_dir,
  input  logic                  inh,
  input  logic                  zero,
  cdu_pulse_scheduler_if.master cif,
  output logic [2:0]            ovf,
  output logic                  toerr
);
  localparam int TW   = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int CMAX = 2 ** (CNT_W - 1) - 1;
  localparam int CMIN = -(2 ** (CNT_W - 1));

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [2:0][CNT_W-1:0]  cnt;
  logic [2:0][CNT_W-1:0]  cnt_nxt;
  logic [2:0]             ovf_set;
  logic [2:0]             pls;
  logic [2:0]             dir;
  logic [2:0]             nz;
  logic [1:0]             last;
  logic [1:0]             axis_q;
  logic [1:0]             sel;
  logic [1:0]             cand1;
  logic [1:0]             cand2;
  logic                   sign_q;
  logic                   sel_vld;
  logic                   grant;
  logic                   tmo_hit;
  logic                   restore;
  logic                   exit_q;
  logic                   rest_vld;
  logic                   req;
  logic [TW-1:0]          tmo_cnt;

  function automatic logic [1:0] rr_next(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  assign pls = {c_pls, b_pls, a_pls};
  assign dir = {c_dir, b_dir, a_dir};

  always_comb begin
    nz = '0;
    for (int i = 0; i < 3; i++) nz[i] = (cnt[i] != '0);
  end

  // Search starts just after the last granted axis, so last itself is tried last.
  always_comb begin
    cand1   = rr_next(last);
    cand2   = rr_next(cand1);
    sel_vld = |nz;
    sel     = last;
    if (nz[cand1])     sel = cand1;
    else if (nz[cand2]) sel = cand2;
  end

  assign grant   = (state == IDLE) && slot && !inh && !zero && !exit_q && sel_vld;
  assign tmo_hit = (state == ISSUE) && slot && !cif.out_ack && (tmo_cnt == TW'(TMO - 1));
  assign restore = tmo_hit && rest_vld && !zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      IDLE: begin
        if (grant) state_nxt = ISSUE;
      end
      ISSUE: begin
        req = 1'b1;
        if (cif.out_ack || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Input pulse, grant step and timeout restore fold into one net change before saturation.
  always_comb begin
    int d;
    int s;
    d       = 0;
    s       = 0;
    ovf_set = '0;
    cnt_nxt = cnt;
    for (int i = 0; i < 3; i++) begin
      d = 0;
      if (pls[i]) d = dir[i] ? 1 : -1;
      if (grant && sel == 2'(i)) d = d + (cnt[i][CNT_W-1] ? 1 : -1);
      if (restore && axis_q == 2'(i)) d = d + (sign_q ? -1 : 1);
      s = int'($signed(cnt[i])) + d;
      if (s > CMAX) begin
        s          = CMAX;
        ovf_set[i] = 1'b1;
      end else if (s < CMIN) begin
        s          = CMIN;
        ovf_set[i] = 1'b1;
      end
      cnt_nxt[i] = CNT_W'(s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ovf      <= '0;
      toerr    <= 1'b0;
      last     <= 2'd2;
      axis_q   <= 2'd0;
      sign_q   <= 1'b0;
      tmo_cnt  <= '0;
      rest_vld <= 1'b0;
      exit_q   <= 1'b0;
    end else begin
      exit_q <= (state == ISSUE) && (state_nxt == IDLE);
      if (zero) begin
        cnt   <= '0;
        ovf   <= '0;
        toerr <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        ovf <= ovf | ovf_set;
        if (tmo_hit) toerr <= 1'b1;
      end
      if (grant) begin
        last     <= sel;
        axis_q   <= sel;
        sign_q   <= cnt[sel][CNT_W-1];
        tmo_cnt  <= '0;
        rest_vld <= 1'b1;
      end else if (state == ISSUE) begin
        if (slot) tmo_cnt <= tmo_cnt + TW'(1);
        // A clear while issuing means the granted pulse must not come back on timeout.
        if (zero) rest_vld <= 1'b0;
      end
    end
  end

  assign cif.out_req  = req;
  assign cif.out_axis = axis_q;
  assign cif.out_sign = sign_q;
endmodule

// File: doc/cdu_pulse_scheduler.md
CDU_PULSE_SCHEDULER -- requirements
Module: cdu_pulse_scheduler

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, the width of each signed per-axis pending-pulse counter.
REQ-002 The block SHALL have parameter TMO, default 4, the number of slot strobes allowed for acknowledge before timeout.
REQ-003 clk  in  1  single system clock; all state SHALL change only on its rising edge, except on reset.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 SLOT  in  1  one-cycle slot strobe from the phase/divider timing chain; opens one grant opportunity.
REQ-006 A_PLS, B_PLS, C_PLS  in  1 each  one-cycle angle-increment pulse per axis.
REQ-007 A_DIR, B_DIR, C_DIR  in  1 each  direction qualifying the matching _PLS: 1 = plus, 0 = minus.
REQ-008 INH  in  1  grant inhibit, for example during coarse align.
REQ-009 ZERO  in  1  level; clears all counters and sticky flags.
REQ-010 OUT_REQ  out  1  pulse request to the computer interface.
REQ-011 OUT_AXIS  out  2  granted axis: 0 = A, 1 = B, 2 = C; 3 is never driven.
REQ-012 OUT_SIGN  out  1  granted pulse sign: 0 = plus, 1 = minus.
REQ-013 OUT_ACK  in  1  acknowledge from the computer interface.
REQ-014 OVF  out  3  sticky per-axis counter saturation flag, bit 0 = A.
REQ-015 TOERR  out  1  sticky acknowledge-timeout flag.

Function
REQ-016 Each axis counter SHALL be two's complement CNT_W bits, spanning -2^(CNT_W-1) to 2^(CNT_W-1)-1.
REQ-017 An input plus pulse SHALL add 1 to its axis counter, and an input minus pulse SHALL subtract 1.
REQ-018 A counter at its limit SHALL hold its value on a further pulse in the same direction, and the matching OVF bit SHALL set.
REQ-019 The FSM SHALL have exactly two states, IDLE and ISSUE, and SHALL reset to IDLE.
REQ-020 In IDLE, with SLOT=1, INH=0, ZERO=0 and at least one nonzero counter, the block SHALL grant exactly one axis and enter ISSUE on the next edge.
REQ-021 Grant selection SHALL be round-robin, searching from the axis after the last-granted axis (A→B→C→A); after reset the last-granted axis SHALL be C.
REQ-022 At grant, OUT_SIGN SHALL be 0 if the granted counter is positive and 1 if it is negative.
REQ-023 At grant, the granted counter SHALL move one step toward zero in that same edge.
REQ-024 An input pulse on the granted axis in the grant cycle SHALL combine with the grant step as a single net change, saturating as in REQ-018.
REQ-025 In ISSUE, OUT_REQ SHALL be 1, and OUT_AXIS and OUT_SIGN SHALL stay constant.
REQ-026 OUT_ACK sampled high in ISSUE SHALL return the FSM to IDLE, with OUT_REQ=0 from the next cycle.
REQ-027 No grant SHALL occur in the cycle after ISSUE exits.
REQ-028 SLOT in ISSUE SHALL not be queued; it SHALL only advance the timeout count.
REQ-029 OUT_ACK while in IDLE SHALL be ignored.
REQ-030 If TMO slot strobes occur in ISSUE without OUT_ACK, the FSM SHALL return to IDLE, TOERR SHALL set, and the granted pulse SHALL be returned to its counter (one step away from zero, saturating).
REQ-031 OUT_ACK and the TMO-th SLOT in the same cycle SHALL count as an acknowledge: no timeout, no restore.
REQ-032 INH SHALL block new grants only; an ISSUE already in progress SHALL complete normally.
REQ-033 INH SHALL not stop counter accumulation.
REQ-034 ZERO SHALL clear all counters, OVF and TOERR each cycle it is high, and input pulses in those cycles SHALL be discarded.
REQ-035 ZERO during ISSUE SHALL not abort the request, and a later timeout SHALL not restore the pulse.
REQ-036 Latency SHALL be one cycle from a SLOT edge to OUT_REQ=1.
REQ-037 At most one grant SHALL occur per SLOT strobe.

Reset
REQ-038 While rst_n=0, all counters, OVF, TOERR, OUT_REQ, OUT_AXIS and OUT_SIGN SHALL be 0 and the FSM SHALL be in IDLE, regardless of clk.
REQ-039 After rst_n is released mid-ISSUE, the interrupted request SHALL be lost with no restore, and operation SHALL resume from the REQ-038 state.

Verification
REQ-040 Three A plus pulses, then SLOT with ACK returned each time → three grants, each OUT_AXIS=0 and OUT_SIGN=0; the A counter reads 2, 1, 0 after each grant.
REQ-041 A=+1, B=-1, C=+1, then three SLOT/ACK rounds → OUT_AXIS sequence 0, 1, 2 with OUT_SIGN 0, 1, 0; a fourth SLOT gives no OUT_REQ.
REQ-042 Nine B minus pulses with CNT_W=4 → B counter is -8 and OVF=3'b010; ZERO then clears both.
REQ-043 A=+2, grant, no ACK for 4 SLOTs → TOERR=1, OUT_REQ=0, A counter back to +2.
REQ-044 A plus pulse in the grant cycle with A=+1 → A counter stays +1 and the grant is issued.
REQ-045 INH=1 with pending counts and a SLOT → no OUT_REQ; INH raised during ISSUE → ISSUE completes on ACK.
